// File: rtl/rv32_exec_datapath.sv
// RV32I execute slice: instruction decode, 32-entry register file and ALU.
// All outputs are combinational functions of the instruction, the PC and
// the register contents. Only the register file holds state.
module rv32_exec_datapath #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [31:0]     i_instruction,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_write_enable,
  output logic [XLEN-1:0] o_alu_result,
  output logic            o_alu_zero,
  output logic [XLEN-1:0] o_immediate,
  output logic [1:0]      o_branch_condition,
  output logic            o_memory_write_enable,
  output logic [XLEN-1:0] o_store_data
);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_JUMP = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_e;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt;
  logic [4:0] rs1_idx, rs2_idx, rd_idx;

  assign opcode  = i_instruction[6:0];
  assign funct3  = i_instruction[14:12];
  assign alt     = i_instruction[30];
  assign rs1_idx = i_instruction[19:15];
  assign rs2_idx = i_instruction[24:20];
  assign rd_idx  = i_instruction[11:7];

  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] rs1_data, rs2_data;

  // x0 is hardwired to zero regardless of array contents.
  assign rs1_data = (rs1_idx == 5'd0) ? '0 : regs[rs1_idx];
  assign rs2_data = (rs2_idx == 5'd0) ? '0 : regs[rs2_idx];

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{(XLEN-12){i_instruction[31]}}, i_instruction[31:20]};
  assign imm_s = {{(XLEN-12){i_instruction[31]}}, i_instruction[31:25], i_instruction[11:7]};
  assign imm_b = {{(XLEN-12){i_instruction[31]}}, i_instruction[7], i_instruction[30:25],
                  i_instruction[11:8], 1'b0};
  assign imm_u = {i_instruction[31:12], 12'b0};
  assign imm_j = {{(XLEN-20){i_instruction[31]}}, i_instruction[19:12], i_instruction[20],
                  i_instruction[30:21], 1'b0};

  alu_op_e         alu_op;
  logic [XLEN-1:0] op1, op2;
  logic            rd_we;

  // Decode: select ALU operation, operands, immediate and control outputs.
  always_comb begin
    alu_op                = ALU_ADD;
    op1                   = rs1_data;
    op2                   = rs2_data;
    o_immediate           = '0;
    rd_we                 = 1'b0;
    o_memory_write_enable = 1'b0;
    o_branch_condition    = BR_NONE;
    case (opcode)
      OPC_OP_IMM, OPC_OP: begin
        rd_we = 1'b1;
        if (opcode == OPC_OP_IMM) begin
          op2         = imm_i;
          o_immediate = imm_i;
        end
        case (funct3)
          3'b000:  alu_op = (opcode == OPC_OP && alt) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_op = ALU_SLL;
          3'b010:  alu_op = ALU_SLT;
          3'b011:  alu_op = ALU_SLTU;
          3'b100:  alu_op = ALU_XOR;
          3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
          3'b110:  alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
      OPC_LUI: begin
        rd_we       = 1'b1;
        op1         = '0;
        op2         = imm_u;
        o_immediate = imm_u;
      end
      OPC_JAL: begin
        rd_we              = 1'b1;
        op1                = i_pc;
        op2                = XLEN'(4);
        o_immediate        = imm_j;
        o_branch_condition = BR_JUMP;
      end
      OPC_BRANCH: begin
        if (funct3 == 3'b001) begin
          alu_op             = ALU_SUB;
          o_immediate        = imm_b;
          o_branch_condition = BR_BNE;
        end
      end
      OPC_STORE: begin
        if (funct3 == 3'b010) begin
          op2                   = imm_s;
          o_immediate           = imm_s;
          o_memory_write_enable = 1'b1;
        end
      end
      default: ;
    endcase
  end

  logic signed [XLEN-1:0] op1_s, op2_s;
  logic [4:0]             shamt;

  assign op1_s = op1;
  assign op2_s = op2;
  assign shamt = op2[4:0];

  // ALU: wrap-around arithmetic, signed/unsigned compares, logical/arithmetic shifts.
  always_comb begin
    o_alu_result = '0;
    case (alu_op)
      ALU_ADD:  o_alu_result = op1 + op2;
      ALU_SUB:  o_alu_result = op1 - op2;
      ALU_SLL:  o_alu_result = op1 << shamt;
      ALU_SLT:  o_alu_result = {{(XLEN-1){1'b0}}, (op1_s < op2_s)};
      ALU_SLTU: o_alu_result = {{(XLEN-1){1'b0}}, (op1 < op2)};
      ALU_XOR:  o_alu_result = op1 ^ op2;
      ALU_SRL:  o_alu_result = op1 >> shamt;
      ALU_SRA:  o_alu_result = op1_s >>> shamt;
      ALU_OR:   o_alu_result = op1 | op2;
      ALU_AND:  o_alu_result = op1 & op2;
      default:  o_alu_result = '0;
    endcase
  end

  assign o_alu_zero   = (o_alu_result == '0);
  assign o_store_data = rs2_data;

  // Register file write port; reset clears every entry and wins over a pending write.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (i_write_enable && rd_we && (rd_idx != 5'd0)) begin
      regs[rd_idx] <= o_alu_result;
    end
  end

endmodule

// File: tb/tb_rv32_exec_datapath.sv
// Randomised scoreboard bench for rv32_exec_datapath with a behavioural RV32I model.
module tb_rv32_exec_datapath;

  logic        clk, rst, we;
  logic [31:0] instr, pc;
  logic [31:0] alu, imm, sd;
  logic        zero, mwe;
  logic [1:0]  br;

  rv32_exec_datapath dut (
    .i_clk(clk), .i_reset(rst), .i_instruction(instr), .i_pc(pc),
    .i_write_enable(we), .o_alu_result(alu), .o_alu_zero(zero),
    .o_immediate(imm), .o_branch_condition(br),
    .o_memory_write_enable(mwe), .o_store_data(sd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          chk_alu;
    logic [31:0] alu;
    logic        zero;
    bit          chk_imm;
    logic [31:0] imm;
    logic [1:0]  br;
    logic        mwe;
    logic [31:0] sd;
    bit          chk_k;
    logic [31:0] k;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] mregs [32];
  bit          sample_tick = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {im, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {im[11:5], rs2, rs1, f3, im[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] im, input logic [4:0] rd);
    return {im[20], im[10:1], im[11], im[19:12], rd, 7'h6F};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [31:0] rreg(input logic [4:0] i);
    return (i == 5'd0) ? 32'h0 : mregs[i];
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] f3, input bit alt,
                                          input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? ((a >> sh) | (a[31] ? ~(32'hFFFFFFFF >> sh) : 32'h0)) : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic void model(input logic [31:0] ins, input logic [31:0] pcv,
                                output exp_t e, output bit w, output logic [31:0] wd);
    logic [31:0] a, b, r, im;
    int v;
    a = rreg(ins[19:15]);
    b = rreg(ins[24:20]);
    r = 32'h0; im = 32'h0; w = 1'b0;
    e.chk_alu = 1'b0; e.chk_imm = 1'b0; e.br = 2'b00; e.mwe = 1'b0;
    e.sd = b; e.chk_k = 1'b0; e.k = 32'h0;
    case (ins[6:0])
      7'h13: begin
        v  = int'(ins[30:20]) - (ins[31] ? 2048 : 0);
        im = 32'(v);
        r  = ref_alu(ins[14:12], ins[30] && ins[14:12] == 3'd5, a, im);
        w = 1'b1; e.chk_alu = 1'b1; e.chk_imm = 1'b1;
      end
      7'h33: begin
        r = ref_alu(ins[14:12], ins[30], a, b);
        w = 1'b1; e.chk_alu = 1'b1;
      end
      7'h37: begin
        r = 32'(ins[31:12]) << 12;
        w = 1'b1; e.chk_alu = 1'b1;
      end
      7'h6F: begin
        v  = int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2
             - (ins[31] ? 1048576 : 0);
        im = 32'(v);
        r  = pcv + 32'd4;
        w = 1'b1; e.chk_alu = 1'b1; e.chk_imm = 1'b1; e.br = 2'b01;
      end
      7'h63: if (ins[14:12] == 3'd1) begin
        v  = int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2
             - (ins[31] ? 4096 : 0);
        im = 32'(v);
        r  = a - b;
        e.chk_alu = 1'b1; e.chk_imm = 1'b1; e.br = 2'b10;
      end
      7'h23: if (ins[14:12] == 3'd2) begin
        v  = int'(ins[30:25]) * 32 + int'(ins[11:7]) - (ins[31] ? 2048 : 0);
        im = 32'(v);
        r  = a + im;
        e.chk_alu = 1'b1; e.chk_imm = 1'b1; e.mwe = 1'b1;
      end
      default: ;
    endcase
    e.alu = r; e.zero = (r == 32'h0); e.imm = im; wd = r;
  endfunction

  // ---------------- stimulus ----------------
  task automatic exec(input string nm, input logic [31:0] ins, input logic [31:0] pcv,
                      input bit pulse, input bit chk_k, input logic [31:0] k);
    exp_t e;
    bit w;
    logic [31:0] wd;
    instr = ins; pc = pcv;
    #1;
    model(ins, pcv, e, w, wd);
    e.name = nm; e.chk_k = chk_k; e.k = k;
    sb.push_back(e);
    sample_tick = ~sample_tick;
    #1;
    if (pulse) begin
      we = 1'b1;
      @(posedge clk);
      #1;
      we = 1'b0;
      if (w && ins[11:7] != 5'd0) mregs[ins[11:7]] = wd;
    end
  endtask

  task automatic dump(input string tag, input bit expect_zero);
    for (int i = 0; i < 32; i++)
      exec($sformatf("%s_x%0d", tag, i), enc_r(7'h0, 5'(i), 5'(i), 3'd6, 5'd0), 32'h0,
           1'b0, expect_zero, 32'h0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd  = 5'($urandom);
    logic [4:0]  rs1 = 5'($urandom);
    logic [4:0]  rs2 = 5'($urandom);
    logic [2:0]  f3  = 3'($urandom);
    logic [11:0] i12 = 12'($urandom);
    logic [6:0]  f7;
    logic [31:0] raw;
    case ($urandom_range(0, 8))
      0, 1: begin
        if (f3 == 3'd1) i12[11:5] = 7'h00;
        if (f3 == 3'd5) i12[11:5] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return enc_i(i12, rs1, f3, rd, 7'h13);
      end
      2, 3: begin
        f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return enc_r(f7, rs2, rs1, f3, rd);
      end
      4: return {20'($urandom), rd, 7'h37};
      5: return enc_j({20'($urandom), 1'b0}, rd);
      6: begin
        if ($urandom_range(0, 2) == 0) rs2 = rs1;
        if ($urandom_range(0, 3) != 0) f3 = 3'd1;
        return enc_b({12'($urandom), 1'b0}, rs2, rs1, f3);
      end
      7: begin
        if ($urandom_range(0, 3) != 0) f3 = 3'd2;
        return enc_s(i12, rs2, rs1, f3);
      end
      default: begin
        raw = $urandom;
        case ($urandom_range(0, 3))
          0: raw = 32'h0;
          1: raw[6:0] = 7'h03;
          2: raw[6:0] = 7'h0F;
          default: raw[6:0] = 7'h73;
        endcase
        return raw;
      end
    endcase
  endfunction

  // Monitor: every presented sample is compared against the oldest expectation.
  initial begin
    forever begin
      @(sample_tick);
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL monitor: sample with empty scoreboard, got alu %h", alu);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, ".br"},  32'(br),  32'(mon_e.br));
        check({mon_e.name, ".mwe"}, 32'(mwe), 32'(mon_e.mwe));
        check({mon_e.name, ".sd"},  sd, mon_e.sd);
        if (mon_e.chk_alu) begin
          check({mon_e.name, ".alu"},  alu, mon_e.alu);
          check({mon_e.name, ".zero"}, 32'(zero), 32'(mon_e.zero));
        end
        if (mon_e.chk_imm) check({mon_e.name, ".imm"}, imm, mon_e.imm);
        if (mon_e.chk_k)   check({mon_e.name, ".const"}, alu, mon_e.k);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    rst = 1'b1; we = 1'b0; instr = 32'h0; pc = 32'h0;
    #12;
    rst = 1'b0;
    @(posedge clk); #1;
    dump("reset", 1'b1);

    exec("addi_x1_5",    32'h00500093,                              32'h0, 1, 1, 32'd5);
    exec("add_x2",       enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2),      32'h0, 1, 1, 32'd10);
    exec("addi_x0_7",    enc_i(12'd7, 5'd0, 3'd0, 5'd0, 7'h13),     32'h0, 1, 1, 32'd7);
    exec("add_x3_x0",    enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd3),      32'h0, 1, 1, 32'd0);
    exec("sub_x4",       enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4),      32'h0, 1, 1, 32'hFFFFFFFB);
    exec("addi_x1_m16",  enc_i(12'hFF0, 5'd0, 3'd0, 5'd1, 7'h13),   32'h0, 1, 1, 32'hFFFFFFF0);
    exec("srai",         enc_i(12'h402, 5'd1, 3'd5, 5'd6, 7'h13),   32'h0, 1, 1, 32'hFFFFFFFC);
    exec("srli",         enc_i(12'h002, 5'd1, 3'd5, 5'd7, 7'h13),   32'h0, 1, 1, 32'h3FFFFFFC);
    exec("slt",          enc_r(7'h00, 5'd0, 5'd1, 3'd2, 5'd8),      32'h0, 1, 1, 32'd1);
    exec("sltu",         enc_r(7'h00, 5'd0, 5'd1, 3'd3, 5'd9),      32'h0, 1, 1, 32'd0);
    exec("lui",          {20'h12345, 5'd5, 7'h37},                  32'h0, 1, 1, 32'h12345000);
    exec("bne_ne",       enc_b(13'h1FF8, 5'd2, 5'd1, 3'd1),         32'h40, 0, 1, 32'hFFFFFFE6);
    exec("bne_eq",       enc_b(13'h1FF8, 5'd0, 5'd3, 3'd1),         32'h40, 1, 1, 32'h0);
    dump("after_bne", 1'b0);
    exec("jal",          enc_j(21'd16, 5'd1),                       32'h20, 1, 1, 32'h24);
    exec("sw",           enc_s(12'd4, 5'd2, 5'd1, 3'd2),            32'h24, 0, 1, 32'h28);
    exec("beq_nop",      enc_b(13'h0010, 5'd1, 5'd1, 3'd0),         32'h50, 1, 0, 32'h0);
    exec("zero_nop",     32'h0,                                     32'h54, 1, 0, 32'h0);

    for (int i = 1; i < 32; i++)
      exec("seed", enc_i(12'($urandom), 5'd0, 3'd0, 5'(i), 7'h13), 32'h0, 1, 0, 32'h0);
    for (int n = 0; n < 400; n++)
      exec($sformatf("rnd%0d", n), rand_instr(), $urandom & 32'hFFFFFFFC, 1, 0, 32'h0);
    dump("after_rnd", 1'b0);

    // Asynchronous reset between edges while a write pulse is pending.
    exec("ld_x9", enc_i(12'h055, 5'd0, 3'd0, 5'd9, 7'h13), 32'h0, 1, 1, 32'h55);
    @(posedge clk); #1;
    instr = enc_i(12'd9, 5'd0, 3'd0, 5'd7, 7'h13);
    we = 1'b1;
    #2;
    rst = 1'b1;
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    exec("rst_mid", enc_i(12'd9, 5'd0, 3'd0, 5'd7, 7'h13), 32'h0, 0, 1, 32'd9);
    @(posedge clk); #2;
    we = 1'b0;
    rst = 1'b0;
    dump("async_rst", 1'b1);

    for (int t = 0; t < 20 && sb.size() != 0; t++) #1;
    check("sb_drain", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
